// File: rtl/flags_pkg.sv
// rtl/flags_pkg.sv - shared bit positions, P image type and reset image for status_flags_gen
package flags_pkg;

    // Bit positions inside the 8-bit processor status image
    localparam int C_BIT = 0;
    localparam int Z_BIT = 1;
    localparam int I_BIT = 2;
    localparam int D_BIT = 3;
    localparam int B_BIT = 4;
    localparam int U_BIT = 5;
    localparam int V_BIT = 6;
    localparam int N_BIT = 7;

    typedef logic [7:0] p_image_t;

    // Only I is set out of reset
    localparam p_image_t P_RESET = 8'h04;

endpackage

// File: rtl/so_edge_sync.sv
// rtl/so_edge_sync.sv - SO pad synchroniser with falling-edge detect
//
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset; all stages reset to 1 (pad idle level)
//   pad    in   asynchronous pad input
//   fall   out  one-cycle pulse when the synchronised pad value goes 1 -> 0
module so_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pad};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign fall = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/status_flags_gen.sv
// rtl/status_flags_gen.sv - processor status register with SO edge latch and optional shadow stack
//
// Build option: FLAGS_SHADOW_EN enables the interrupt shadow stack; without it push only
// forces I, pop is ignored and the stack status outputs are constant.
//
// Ports:
//   PHI0, n_RES              clock, asynchronous active-low reset
//   DB_in / DB_out / DB_oe   internal data bus in, P image out, bus drive enable (= P_DB)
//   P_DB, DB_P               drive P onto bus / load all flags from DB_in[7:0]
//   DBZ_Z, DB_N              Z from DB_in==0 / N from DB_in msb
//   IR5_C, DB_C, ACR_C       C sources
//   IR5_D, IR5_I             D / I from IR5
//   DB_V, Z_V, AVR_V         V from DB_in[6] / clear V / V from AVR
//   IR5, ACR, AVR, B_OUT     data sources
//   SO_frompad               asynchronous set-overflow pad, active on falling edge
//   push, pop                interrupt entry / return strobes
//   C, Z, I, D, V, N         registered flags
//   shadow_full/empty/err    stack status; err is sticky until reset
module status_flags_gen
    import flags_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int SHADOW_DEPTH = 4,
    parameter int SO_SYNC      = 2
) (
    input  logic              PHI0,
    input  logic              n_RES,
    input  logic [DATA_W-1:0] DB_in,
    output logic [DATA_W-1:0] DB_out,
    output logic              DB_oe,
    input  logic              P_DB,
    input  logic              DB_P,
    input  logic              DBZ_Z,
    input  logic              DB_N,
    input  logic              IR5_C,
    input  logic              DB_C,
    input  logic              ACR_C,
    input  logic              IR5_D,
    input  logic              IR5_I,
    input  logic              DB_V,
    input  logic              Z_V,
    input  logic              AVR_V,
    input  logic              IR5,
    input  logic              ACR,
    input  logic              AVR,
    input  logic              B_OUT,
    input  logic              SO_frompad,
    input  logic              push,
    input  logic              pop,
    output logic              C,
    output logic              Z,
    output logic              I,
    output logic              D,
    output logic              V,
    output logic              N,
    output logic              shadow_full,
    output logic              shadow_empty,
    output logic              shadow_err
);

    p_image_t p_now;
    p_image_t top_entry;
    logic     restore;
    logic     so_fall;
    logic     so_pend;
    logic     so_trig;
    logic     v_write;
    logic [1:0] unused_top_bits;

    assign p_now  = {N, V, 1'b1, B_OUT, D, I, Z, C};
    assign DB_out = DATA_W'(p_now);
    assign DB_oe  = P_DB;

    so_edge_sync #(.STAGES(SO_SYNC)) u_so_edge_sync (
        .clk   (PHI0),
        .rst_n (n_RES),
        .pad   (SO_frompad),
        .fall  (so_fall)
    );

`ifdef FLAGS_SHADOW_EN
    localparam int DW = $clog2(SHADOW_DEPTH + 1);
    localparam int AW = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

    p_image_t      stack_mem [SHADOW_DEPTH];
    logic [DW-1:0] depth;
    logic          err_q;
    logic          do_push;

    assign shadow_full  = (depth == DW'(SHADOW_DEPTH));
    assign shadow_empty = (depth == '0);
    assign shadow_err   = err_q;
    assign do_push      = push & ~shadow_full;
    // push wins a simultaneous push/pop, so pop only acts alone
    assign restore      = pop & ~push & ~shadow_empty;
    assign top_entry    = stack_mem[AW'(depth - DW'(1))];

    always_ff @(posedge PHI0) begin
        if (do_push) begin
            stack_mem[AW'(depth)] <= p_now;
        end
    end

    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            depth <= '0;
            err_q <= 1'b0;
        end else begin
            if (do_push) begin
                depth <= depth + DW'(1);
            end else if (restore) begin
                depth <= depth - DW'(1);
            end
            if ((push & shadow_full) | (pop & ~push & shadow_empty)) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    localparam int UNUSED_DEPTH = SHADOW_DEPTH;
    logic unused_pop;

    assign unused_pop   = pop;
    assign restore      = 1'b0;
    assign top_entry    = P_RESET;
    assign shadow_full  = 1'b0;
    assign shadow_empty = 1'b1;
    assign shadow_err   = 1'b0;
`endif

    assign unused_top_bits = {top_entry[B_BIT], top_entry[U_BIT]};

    // A pending SO (or one arriving this cycle) waits out any cycle that writes V
    assign v_write = restore | DB_P | DB_V | AVR_V | Z_V;
    assign so_trig = so_fall | so_pend;

    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            C       <= P_RESET[C_BIT];
            Z       <= P_RESET[Z_BIT];
            I       <= P_RESET[I_BIT];
            D       <= P_RESET[D_BIT];
            V       <= P_RESET[V_BIT];
            N       <= P_RESET[N_BIT];
            so_pend <= 1'b0;
        end else begin
            so_pend <= so_trig & v_write;

            if (restore)    C <= top_entry[C_BIT];
            else if (DB_P)  C <= DB_in[C_BIT];
            else if (ACR_C) C <= ACR;
            else if (DB_C)  C <= DB_in[C_BIT];
            else if (IR5_C) C <= IR5;

            if (restore)    Z <= top_entry[Z_BIT];
            else if (DB_P)  Z <= DB_in[Z_BIT];
            else if (DBZ_Z) Z <= (DB_in == '0);

            // Interrupt entry always masks, whatever else targets I this cycle
            if (push)       I <= 1'b1;
            else if (restore) I <= top_entry[I_BIT];
            else if (DB_P)  I <= DB_in[I_BIT];
            else if (IR5_I) I <= IR5;

            if (restore)    D <= top_entry[D_BIT];
            else if (DB_P)  D <= DB_in[D_BIT];
            else if (IR5_D) D <= IR5;

            if (restore)      V <= top_entry[V_BIT];
            else if (DB_P)    V <= DB_in[V_BIT];
            else if (DB_V)    V <= DB_in[V_BIT];
            else if (AVR_V)   V <= AVR;
            else if (Z_V)     V <= 1'b0;
            else if (so_trig) V <= 1'b1;

            if (restore)    N <= top_entry[N_BIT];
            else if (DB_P)  N <= DB_in[N_BIT];
            else if (DB_N)  N <= DB_in[DATA_W-1];
        end
    end

endmodule

// File: tb/tb_status_flags_gen.sv
// tb/tb_status_flags_gen.sv - directed self-checking bench for status_flags_gen
module tb_status_flags_gen;

    localparam int DATA_W = 16;
`ifdef FLAGS_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic PHI0 = 1'b0;
    logic n_RES;
    logic [DATA_W-1:0] DB_in, DB_out;
    logic DB_oe, P_DB, DB_P, DBZ_Z, DB_N, IR5_C, DB_C, ACR_C, IR5_D, IR5_I;
    logic DB_V, Z_V, AVR_V, IR5, ACR, AVR, B_OUT, SO_frompad, push, pop;
    logic C, Z, I, D, V, N, shadow_full, shadow_empty, shadow_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 PHI0 = ~PHI0;

    status_flags_gen #(.DATA_W(DATA_W), .SHADOW_DEPTH(2), .SO_SYNC(2)) dut (
        .PHI0(PHI0), .n_RES(n_RES), .DB_in(DB_in), .DB_out(DB_out), .DB_oe(DB_oe),
        .P_DB(P_DB), .DB_P(DB_P), .DBZ_Z(DBZ_Z), .DB_N(DB_N), .IR5_C(IR5_C),
        .DB_C(DB_C), .ACR_C(ACR_C), .IR5_D(IR5_D), .IR5_I(IR5_I), .DB_V(DB_V),
        .Z_V(Z_V), .AVR_V(AVR_V), .IR5(IR5), .ACR(ACR), .AVR(AVR), .B_OUT(B_OUT),
        .SO_frompad(SO_frompad), .push(push), .pop(pop), .C(C), .Z(Z), .I(I),
        .D(D), .V(V), .N(N), .shadow_full(shadow_full), .shadow_empty(shadow_empty),
        .shadow_err(shadow_err)
    );

    // flags packed as {N,V,D,I,Z,C}
    function automatic logic [5:0] flags();
        return {N, V, D, I, Z, C};
    endfunction

    task automatic clear_ctl();
        P_DB = 0; DB_P = 0; DBZ_Z = 0; DB_N = 0; IR5_C = 0; DB_C = 0; ACR_C = 0;
        IR5_D = 0; IR5_I = 0; DB_V = 0; Z_V = 0; AVR_V = 0; IR5 = 0; ACR = 0;
        AVR = 0; B_OUT = 0; push = 0; pop = 0; DB_in = '0;
    endtask

    // one rising edge, then settle away from the edge; strobes drop afterwards
    task automatic step();
        @(posedge PHI0);
        #1;
        clear_ctl();
    endtask

    task automatic test_reset();
        clear_ctl();
        SO_frompad = 1;
        n_RES = 0;
        #12;
        vectors++;
        if (flags() !== 6'b000100) begin
            miscompares++; $display("FAIL reset_flags got %b exp %b", flags(), 6'b000100);
        end
        vectors++;
        if ({shadow_full, shadow_empty, shadow_err} !== 3'b010) begin
            miscompares++; $display("FAIL reset_stack got %b exp 010", {shadow_full, shadow_empty, shadow_err});
        end
        vectors++;
        if (DB_out !== 16'h0024 || DB_oe !== 1'b0) begin
            miscompares++; $display("FAIL reset_dbout got %h/%b exp 0024/0", DB_out, DB_oe);
        end
        @(negedge PHI0);
        n_RES = 1;
        step();
    endtask

    task automatic test_db_load();
        DB_in = 16'h00FF; DB_P = 1;
        step();
        vectors++;
        if (flags() !== 6'b111111) begin
            miscompares++; $display("FAIL dbp_all got %b exp 111111", flags());
        end
        P_DB = 1; B_OUT = 1;
        #1;
        vectors++;
        if (DB_out !== 16'h00FF || DB_oe !== 1'b1) begin
            miscompares++; $display("FAIL pdb_b1 got %h/%b exp 00FF/1", DB_out, DB_oe);
        end
        B_OUT = 0;
        #1;
        vectors++;
        if (DB_out !== 16'h00EF) begin
            miscompares++; $display("FAIL pdb_b0 got %h exp 00EF", DB_out);
        end
        clear_ctl();
    endtask

    task automatic test_zn();
        DB_in = 16'h8000; DBZ_Z = 1; DB_N = 1;
        step();
        vectors++;
        if ({Z, N} !== 2'b01) begin
            miscompares++; $display("FAIL zn_8000 got Z=%b N=%b exp Z=0 N=1", Z, N);
        end
        DB_in = 16'h0000; DBZ_Z = 1;
        step();
        vectors++;
        if ({Z, N} !== 2'b11) begin
            miscompares++; $display("FAIL z_zero got Z=%b N=%b exp Z=1 N=1", Z, N);
        end
        DB_in = 16'h0100; DBZ_Z = 1; DB_N = 1;
        step();
        vectors++;
        if ({Z, N} !== 2'b00) begin
            miscompares++; $display("FAIL z_upper got Z=%b N=%b exp Z=0 N=0", Z, N);
        end
    endtask

    task automatic test_so();
        logic [2:0] vhist;
        Z_V = 1;
        step();
        SO_frompad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            vhist[k] = V;
        end
        vectors++;
        if (vhist !== 3'b100) begin
            miscompares++; $display("FAIL so_latency got %b exp 100 (edges 3..1)", vhist);
        end
        SO_frompad = 1;
        for (int k = 0; k < 3; k++) begin
            Z_V = 1;
            step();
        end
        SO_frompad = 0;
        for (int k = 0; k < 5; k++) begin
            Z_V = 1;
            step();
        end
        vectors++;
        if (V !== 1'b0) begin
            miscompares++; $display("FAIL so_blocked got %b exp 0", V);
        end
        step();
        vectors++;
        if (V !== 1'b1) begin
            miscompares++; $display("FAIL so_release got %b exp 1", V);
        end
        Z_V = 1;
        step();
        step();
        vectors++;
        if (V !== 1'b0) begin
            miscompares++; $display("FAIL so_once got %b exp 0", V);
        end
        SO_frompad = 1;
    endtask

    task automatic test_carry();
        DB_in = 16'h0000; DB_C = 1;
        step();
        ACR = 1; DB_in = 16'h0000; ACR_C = 1; DB_C = 1;
        step();
        vectors++;
        if (C !== 1'b1) begin
            miscompares++; $display("FAIL c_acr_prio got %b exp 1", C);
        end
        ACR = 0; DB_in = 16'h0001; ACR_C = 1; DB_C = 1;
        step();
        vectors++;
        if (C !== 1'b0) begin
            miscompares++; $display("FAIL c_acr_over_db got %b exp 0", C);
        end
        IR5 = 1; IR5_C = 1;
        step();
        vectors++;
        if (C !== 1'b1) begin
            miscompares++; $display("FAIL c_ir5 got %b exp 1", C);
        end
    endtask

    task automatic test_push_pop();
        DB_in = 16'h00C3; DB_P = 1;
        step();
        vectors++;
        if (flags() !== 6'b110011) begin
            miscompares++; $display("FAIL load_c3 got %b exp 110011", flags());
        end
        push = 1;
        step();
        vectors++;
        if (flags() !== 6'b110111 || shadow_empty !== !SH) begin
            miscompares++; $display("FAIL push_i got %b/%b exp 110111/%b", flags(), shadow_empty, !SH);
        end
        DB_in = 16'h0000; DB_P = 1;
        step();
        pop = 1;
        step();
        vectors++;
        if (flags() !== (SH ? 6'b110011 : 6'b000000) || shadow_empty !== 1'b1) begin
            miscompares++; $display("FAIL pop_restore got %b/%b exp %b/1", flags(), shadow_empty,
                                    SH ? 6'b110011 : 6'b000000);
        end
    endtask

    task automatic test_overflow();
        DB_in = 16'h0001; DB_P = 1;
        step();
        push = 1;
        step();
        DB_in = 16'h0080; DB_P = 1;
        step();
        push = 1;
        step();
        vectors++;
        if (shadow_full !== SH || shadow_err !== 1'b0) begin
            miscompares++; $display("FAIL full_two got %b/%b exp %b/0", shadow_full, shadow_err, SH);
        end
        DB_in = 16'h0040; DB_P = 1;
        step();
        push = 1;
        step();
        vectors++;
        if (shadow_full !== SH || shadow_err !== SH || I !== 1'b1) begin
            miscompares++; $display("FAIL overflow got %b/%b/%b exp %b/%b/1", shadow_full, shadow_err, I, SH, SH);
        end
        pop = 1;
        step();
        vectors++;
        if (flags() !== (SH ? 6'b100000 : 6'b010100)) begin
            miscompares++; $display("FAIL pop1 got %b exp %b", flags(), SH ? 6'b100000 : 6'b010100);
        end
        pop = 1;
        step();
        vectors++;
        if (flags() !== (SH ? 6'b000001 : 6'b010100)) begin
            miscompares++; $display("FAIL pop2 got %b exp %b", flags(), SH ? 6'b000001 : 6'b010100);
        end
        pop = 1;
        step();
        vectors++;
        if (flags() !== (SH ? 6'b000001 : 6'b010100) || shadow_empty !== 1'b1 || shadow_err !== SH) begin
            miscompares++; $display("FAIL pop3_underflow got %b/%b/%b exp %b/1/%b", flags(), shadow_empty,
                                    shadow_err, SH ? 6'b000001 : 6'b010100, SH);
        end
    endtask

    task automatic test_reset_mid();
        DB_in = 16'h00CB; DB_P = 1;
        step();
        push = 1;
        step();
        push = 1;
        step();
        vectors++;
        if (shadow_full !== SH) begin
            miscompares++; $display("FAIL mid_full got %b exp %b", shadow_full, SH);
        end
        #2;
        n_RES = 0;
        #1;
        vectors++;
        if (flags() !== 6'b000100 || {shadow_full, shadow_empty, shadow_err} !== 3'b010) begin
            miscompares++; $display("FAIL mid_reset got %b/%b exp 000100/010", flags(),
                                    {shadow_full, shadow_empty, shadow_err});
        end
        @(negedge PHI0);
        n_RES = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_db_load();
        test_zn();
        test_so();
        test_carry();
        test_push_pop();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/status_flags_gen.md
Name: status_flags_gen

Overview:
- Parametrised next-generation processor status (P) register for the Core6502 datapath family.
- Holds C, Z, I, D, V, N and drives/loads them over a DATA_W-bit internal data bus.
- Adds over the classic flags block:
  - synchronised, edge-detected SO pad with a pending latch;
  - hardware shadow stack that saves P on interrupt entry and restores it on return.
- Sits beside the ALU and random-logic decoder; all control strobes come from the decoder.

Parameters:
- DATA_W, 8, data bus width (≥8); flags occupy bits [7:0], upper bits read as 0.
- SHADOW_DEPTH, 4, shadow stack entries (≥1).
- SO_SYNC, 2, SO pad synchroniser stages (≥2).

Ports:
- PHI0  in  1  single clock; all state updates on rising edge.
- n_RES  in  1  asynchronous active-low reset.
- DB_in  in  DATA_W  internal data bus value.
- DB_out  out  DATA_W  P image: {0…, N, V, 1, B_OUT, D, I, Z, C}.
- DB_oe  out  1  equals P_DB (combinational).
- P_DB, DB_P  in  1 each  drive P to bus; load all flags from DB_in[7:0].
- DBZ_Z, DB_N  in  1 each  Z from DB_in==0; N from DB_in[DATA_W-1].
- IR5_C, DB_C, ACR_C  in  1 each  C from IR5; C from DB_in[0]; C from ACR.
- IR5_D, IR5_I  in  1 each  D / I from IR5.
- DB_V, Z_V, AVR_V  in  1 each  V from DB_in[6]; clear V; V from AVR.
- IR5, ACR, AVR, B_OUT  in  1 each  data sources.
- SO_frompad  in  1  asynchronous set-overflow pad (active-low edge).
- push, pop  in  1 each  interrupt entry / return strobes.
- C, Z, I, D, V, N  out  1 each  flag values (registered).
- shadow_full, shadow_empty  out  1 each  stack status.
- shadow_err  out  1  sticky overflow/underflow flag, cleared only by reset.

Behaviour:
- Reset (async, n_RES=0):
  - C=Z=V=N=D=0, I=1;
  - SO pending=0, synchroniser filled with 1;
  - stack empty, shadow_err=0.
- Single-cycle latency: strobe sampled at edge k, flag visible after edge k.
- Per-flag priority, highest first:
  1. pop restore;
  2. DB_P;
  3. individual loads;
  4. SO pending (V only).
- Fixed order among individual loads of the same flag:
  - C: ACR_C > DB_C > IR5_C;
  - V: DB_V > AVR_V > Z_V.
- DBZ_Z: Z=1 iff all DATA_W bits of DB_in are 0.
- DB_P: B and bit 5 bits ignored.
- SO path:
  - SO_SYNC-flop synchroniser; falling edge of synced value sets so_pend.
  - so_pend applies V=1 on the first cycle with no V write (pop, DB_P, DB_V, AVR_V, Z_V), then clears.
  - Edge arriving while so_pend=1 merges (no queue).
- push:
  - saves current pre-edge P[7:0] (B bit = B_OUT) to stack top;
  - forces I=1 after the edge, overriding all I sources.
  - Full stack: entry discarded, shadow_err=1, I still set.
- pop:
  - restores C, Z, I, D, V, N from top; decrements depth.
  - Empty stack: flags follow normal loads, shadow_err=1.
- push and pop in the same cycle: push performed, pop ignored (no error).
- DB_out/DB_oe are purely combinational from registered flags.

Optional Feature:
- FLAGS_SHADOW_EN defined: shadow stack as above.
- Undefined:
  - no stack storage;
  - push only forces I=1; pop is ignored (no restore);
  - shadow_full=0, shadow_empty=1, shadow_err=0 constant.

Decomposition:
- Package flags_pkg holds:
  - bit-index constants C_BIT=0, Z_BIT=1, I_BIT=2, D_BIT=3, B_BIT=4, U_BIT=5, V_BIT=6, N_BIT=7;
  - reset image 8'h04;
  - a typedef for the 8-bit P image.
- One sub-module, so_edge_sync: parametrised synchroniser + falling-edge detector, async reset to 1.

Test Plan:
- Reset, then DB_in=8'hFF with DB_P → C=Z=I=D=V=N=1; P_DB gives DB_out=8'hFF (DATA_W=8).
- DATA_W=16, DB_in=16'h8000 with DBZ_Z+DB_N → Z=0, N=1.
- DB_in=0 with DBZ_Z → Z=1.
- SO_frompad 1→0 → V=1 exactly SO_SYNC+1 edges later.
- Repeat the SO edge with Z_V held high → V stays 0 until Z_V drops, then V=1 next edge.
- ACR=1, DB_in[0]=0, ACR_C and DB_C together → C=1.
- P=8'hC3, push → I=1; then DB_P with 0x00, then pop → P restored to C=Z=V=N=1, I=0.
- SHADOW_DEPTH=2: three pushes → shadow_full=1, shadow_err=1.
- Then three pops → third restores nothing, shadow_empty=1.
- Assert n_RES mid-sequence with two entries stacked → immediate I=1, others 0, shadow_empty=1, shadow_err=0.
